term_screen_buffer: RTL and testbench

//  Parametrised character store for the UART terminal: consumes received bytes, tracks a

---
 rtl/term_screen_buffer.sv | 243 ++++++++++++++++++++++++
 tb/tb_term_screen_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/term_screen_buffer.sv
// ----------------------------------------------------------------------------
// term_screen_buffer
//   Character store for the UART terminal. Received bytes are captured on the
//   rising edge of the UART level flag into a one-deep holding register, then
//   decoded: CR/LF/BS/FF move the cursor or clear the screen, and every other
//   byte is written at the cursor. The screen scrolls by advancing a top-row
//   pointer instead of copying rows, so the display always sees logical row 0
//   as the top line.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   byte_ready  UART level flag, 0->1 marks a new byte
//   data        received byte, valid while byte_ready=1
//   rd_row      display read row (logical, 0 = top)
//   rd_col      display read column
//   rd_data     character at (rd_row, rd_col), one cycle after the address
//   cursor_row  logical cursor row
//   cursor_col  cursor column
//   busy        a full-screen or single-line clear is running
//   overrun     sticky, a byte arrived while the holding register was full
// ----------------------------------------------------------------------------
module term_screen_buffer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      byte_ready,
    input  logic [DATA_W-1:0]         data,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [DATA_W-1:0]         rd_data,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic                      busy,
    output logic                      overrun
);

    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [AW-1:0]     COLS_A    = AW'(COLS);
    localparam logic [AW-1:0]     LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0]     LAST_COLA = AW'(COLS - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
    // One bit wider so the range limits survive when ROWS/COLS are powers of two
    localparam logic [RW:0]       ROWS_E    = (RW+1)'(ROWS);
    localparam logic [CW:0]       COLS_E    = (CW+1)'(COLS);
    localparam logic [DATA_W-1:0] CH_SPACE  = DATA_W'(8'h20);
    localparam logic [DATA_W-1:0] CH_CR     = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] CH_LF     = DATA_W'(8'h0A);
    localparam logic [DATA_W-1:0] CH_BS     = DATA_W'(8'h08);
    localparam logic [DATA_W-1:0] CH_FF     = DATA_W'(8'h0C);

    typedef enum logic [1:0] {
        S_CLR_ALL,
        S_IDLE,
        S_CLR_LINE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       w_cnt_nxt;
    logic [RW-1:0]       r_top_row;
    logic [RW-1:0]       w_top_nxt;
    logic [RW-1:0]       r_cur_row;
    logic [RW-1:0]       w_row_nxt;
    logic [CW-1:0]       r_cur_col;
    logic [CW-1:0]       w_col_nxt;
    logic                r_hold_valid;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_prev_ready;
    logic                r_overrun;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [CELLS];

    logic                w_rise;
    logic                w_pop;
    logic                w_newline;
    logic                w_we;
    logic [AW-1:0]       w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_rd_valid;
    logic [AW-1:0]       w_rd_addr;

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] top,
                                               input logic [RW-1:0] row);
        logic [RW:0] sum;
        sum = {1'b0, top} + {1'b0, row};
        if (sum >= ROWS_E) begin
            sum = sum - ROWS_E;
        end
        return sum[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow,
                                                input logic [CW-1:0] col);
        return AW'(prow) * COLS_A + AW'(col);
    endfunction

    assign w_rise = byte_ready & ~r_prev_ready;

    // Next-state / decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_top_nxt   = r_top_row;
        w_row_nxt   = r_cur_row;
        w_col_nxt   = r_cur_col;
        w_we        = 1'b0;
        w_waddr     = '0;
        w_wdata     = CH_SPACE;
        w_pop       = 1'b0;
        w_newline   = 1'b0;

        case (r_state)
            S_CLR_ALL: begin
                // Sweeps physical cells directly; top_row is 0 whenever we get here
                w_we    = 1'b1;
                w_waddr = r_cnt;
                if (r_cnt == LAST_CELL) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_CLR_LINE: begin
                // top_row has already advanced, so the bottom logical row is the new line
                w_we    = 1'b1;
                w_waddr = cell_addr(phys_row(r_top_row, LAST_ROW), r_cnt[CW-1:0]);
                if (r_cnt == LAST_COLA) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                if (r_hold_valid) begin
                    w_pop = 1'b1;
                    case (r_hold_data)
                        CH_CR: w_col_nxt = '0;
                        CH_LF: w_newline = 1'b1;
                        CH_BS: begin
                            if (r_cur_col != '0) begin
                                w_col_nxt = r_cur_col - 1'b1;
                            end
                        end
                        CH_FF: begin
                            w_row_nxt   = '0;
                            w_col_nxt   = '0;
                            w_top_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_CLR_ALL;
                        end
                        default: begin
                            w_we    = 1'b1;
                            w_waddr = cell_addr(phys_row(r_top_row, r_cur_row), r_cur_col);
                            w_wdata = r_hold_data;
                            if (r_cur_col == LAST_COL) begin
                                w_col_nxt = '0;
                                w_newline = 1'b1;
                            end else begin
                                w_col_nxt = r_cur_col + 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase

        if (w_newline) begin
            if (r_cur_row != LAST_ROW) begin
                w_row_nxt = r_cur_row + 1'b1;
            end else begin
                w_top_nxt   = (r_top_row == LAST_ROW) ? '0 : r_top_row + 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_CLR_LINE;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLR_ALL;
            r_cnt        <= '0;
            r_top_row    <= '0;
            r_cur_row    <= '0;
            r_cur_col    <= '0;
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_prev_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_top_row    <= w_top_nxt;
            r_cur_row    <= w_row_nxt;
            r_cur_col    <= w_col_nxt;
            r_prev_ready <= byte_ready;
            // A slot freed by this cycle's pop can take a new byte immediately
            if (w_rise) begin
                if (r_hold_valid && !w_pop) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_hold_valid <= 1'b1;
                    r_hold_data  <= data;
                end
            end else if (w_pop) begin
                r_hold_valid <= 1'b0;
            end
            r_rd_data <= w_rd_valid ? r_mem[w_rd_addr] : CH_SPACE;
        end
    end

    // Character RAM, blanked by the clear states rather than by reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_rd_valid = ({1'b0, rd_row} < ROWS_E) && ({1'b0, rd_col} < COLS_E);
    assign w_rd_addr  = cell_addr(phys_row(r_top_row, rd_row), rd_col);

    assign rd_data    = r_rd_data;
    assign cursor_row = r_cur_row;
    assign cursor_col = r_cur_col;
    assign busy       = (r_state != S_IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_term_screen_buffer.sv
module tb_term_screen_buffer;

    localparam int COLS = 4;
    localparam int ROWS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] rd_row = 2'd0;
    logic [1:0] rd_col = 2'd0;
    logic [7:0] rd_data;
    logic [1:0] cursor_row;
    logic [1:0] cursor_col;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    term_screen_buffer #(.COLS(COLS), .ROWS(ROWS), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .byte_ready(byte_ready), .data(data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_ready = 1'b1;
        data       = b;
        @(negedge clk);
        byte_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        @(negedge clk);
        rd_row = r[1:0];
        rd_col = c[1:0];
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL reset_cursor got %0d/%0d exp 0/0", cursor_row, cursor_col); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b exp 1", busy); end
        rst_n = 1'b1;
        wait_idle(n);
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL reset_clear_cycles got %0d exp 12", n); end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL reset_blank(%0d,%0d) got %h exp 20", r, c, v); end
            end
        end
    endtask

    task automatic test_basic_write;
        logic [7:0] v;
        send_byte("A");
        send_byte("B");
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 2'd2) begin n_fail++; $display("FAIL ab_cursor got %0d/%0d exp 0/2", cursor_row, cursor_col); end
        read_cell(0, 0, v);
        n_checks++; if (v !== "A") begin n_fail++; $display("FAIL ab_cell00 got %h exp 41", v); end
        read_cell(0, 1, v);
        n_checks++; if (v !== "B") begin n_fail++; $display("FAIL ab_cell01 got %h exp 42", v); end
        read_cell(0, 2, v);
        n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL ab_cell02 got %h exp 20", v); end
        read_cell(3, 0, v);
        n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL rd_row_out_of_range got %h exp 20", v); end
    endtask

    task automatic test_wrap;
        logic [7:0] v;
        logic [7:0] exp_row [4] = '{"W", "X", "Y", "Z"};
        send_byte(8'h0D);
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL cr_cursor got %0d/%0d exp 0/0", cursor_row, cursor_col); end
        for (int i = 0; i < 4; i++) send_byte(exp_row[i]);
        n_checks++; if (cursor_row !== 2'd1 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL wrap_cursor got %0d/%0d exp 1/0", cursor_row, cursor_col); end
        for (int c = 0; c < COLS; c++) begin
            read_cell(0, c, v);
            n_checks++; if (v !== exp_row[c]) begin n_fail++; $display("FAIL wrap_row0(%0d) got %h exp %h", c, v, exp_row[c]); end
        end
    endtask

    task automatic test_scroll;
        logic [7:0] v;
        int n;
        logic [7:0] exp_r0 [4] = '{"a", "b", "c", "d"};
        logic [7:0] exp_r1 [4] = '{"e", "f", 8'h20, 8'h20};
        for (int i = 0; i < 4; i++) send_byte(exp_r0[i]);
        n_checks++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL fill_cursor got %0d/%0d exp 2/0", cursor_row, cursor_col); end
        send_byte("e");
        send_byte("f");
        send_byte(8'h0D);
        send_byte(8'h0A);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL scroll_busy got %b exp 1", busy); end
        wait_idle(n);
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL scroll_clear_cycles got %0d exp 4", n); end
        n_checks++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL scroll_cursor got %0d/%0d exp 2/0", cursor_row, cursor_col); end
        for (int c = 0; c < COLS; c++) begin
            read_cell(0, c, v);
            n_checks++; if (v !== exp_r0[c]) begin n_fail++; $display("FAIL scroll_row0(%0d) got %h exp %h", c, v, exp_r0[c]); end
            read_cell(1, c, v);
            n_checks++; if (v !== exp_r1[c]) begin n_fail++; $display("FAIL scroll_row1(%0d) got %h exp %h", c, v, exp_r1[c]); end
            read_cell(2, c, v);
            n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL scroll_row2(%0d) got %h exp 20", c, v); end
        end
    endtask

    task automatic test_backspace;
        logic [7:0] v;
        send_byte(8'h08);
        n_checks++; if (cursor_row !== 2'd2 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL bs_col0 got %0d/%0d exp 2/0", cursor_row, cursor_col); end
        send_byte("p");
        send_byte("q");
        n_checks++; if (cursor_col !== 2'd2) begin n_fail++; $display("FAIL bs_pre_col got %0d exp 2", cursor_col); end
        send_byte(8'h08);
        n_checks++; if (cursor_row !== 2'd2 || cursor_col !== 2'd1) begin n_fail++; $display("FAIL bs_col2 got %0d/%0d exp 2/1", cursor_row, cursor_col); end
        read_cell(2, 1, v);
        n_checks++; if (v !== "q") begin n_fail++; $display("FAIL bs_no_erase got %h exp 71", v); end
    endtask

    task automatic test_overrun;
        logic [7:0] v;
        @(negedge clk); byte_ready = 1'b1; data = 8'h0A;
        @(negedge clk); byte_ready = 1'b0;
        @(negedge clk); byte_ready = 1'b1; data = "1";
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy got %b exp 1", busy); end
        @(negedge clk); byte_ready = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_held got %b exp 0", overrun); end
        @(negedge clk); byte_ready = 1'b1; data = "2";
        @(negedge clk); byte_ready = 1'b0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_second got %b exp 1", overrun); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_still_busy got %b exp 1", busy); end
        @(negedge clk); byte_ready = 1'b1; data = "3";
        @(negedge clk); byte_ready = 1'b0;
        repeat (4) @(negedge clk);
        read_cell(2, 1, v);
        n_checks++; if (v !== "1") begin n_fail++; $display("FAIL ovr_held_written got %h exp 31", v); end
        read_cell(2, 0, v);
        n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL ovr_row_cleared got %h exp 20", v); end
        read_cell(0, 0, v);
        n_checks++; if (v !== "e") begin n_fail++; $display("FAIL ovr_top_wrap got %h exp 65", v); end
        read_cell(1, 1, v);
        n_checks++; if (v !== "q") begin n_fail++; $display("FAIL ovr_row1 got %h exp 71", v); end
    endtask

    task automatic test_form_feed;
        logic [7:0] v;
        int n;
        send_byte(8'h0C);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ff_busy got %b exp 1", busy); end
        wait_idle(n);
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL ff_clear_cycles got %0d exp 12", n); end
        n_checks++; if (cursor_row !== 2'd0 || cursor_col !== 2'd0) begin n_fail++; $display("FAIL ff_cursor got %0d/%0d exp 0/0", cursor_row, cursor_col); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ff_overrun_sticky got %b exp 1", overrun); end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL ff_blank(%0d,%0d) got %h exp 20", r, c, v); end
            end
        end
    endtask

    task automatic test_reset_midclear;
        logic [7:0] v;
        int n;
        send_byte("K");
        read_cell(0, 0, v);
        n_checks++; if (v !== "K") begin n_fail++; $display("FAIL mid_write got %h exp 4b", v); end
        send_byte(8'h0C);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun got %b exp 0", overrun); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rd_data got %h exp 00", rd_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
        rst_n = 1'b1;
        wait_idle(n);
        n_checks++; if (n != 12) begin n_fail++; $display("FAIL mid_clear_cycles got %0d exp 12", n); end
        read_cell(0, 0, v);
        n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL mid_reblank got %h exp 20", v); end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrap();
        test_scroll();
        test_backspace();
        test_overrun();
        test_form_feed();
        test_reset_midclear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
